axi_ni_target_response: RTL and testbench
=========================================

Name: axi_ni_target_response

Overview:
- Target-side NI block that packetizes AXI write responses (B) and read data (R) from a slave core into response flits for the NoC.
- It is the responder counterpart of the initiator-side response depacketizer.
- It sits between the slave's B/R channels and the target NI out_buffer.
- Return routes are stored per AXI ID by the target request path and looked up when each response packet starts.

Parameters:
- FLIT_WIDTH, 80, flit width in bits; must be ≥ 72.
- MAX_SUPPORTED_IDS, 16, number of route-table entries; the AXI ID indexes the table directly.
- AXIRDATAWD, 64, RDATA width.
- PATHWD, 7, source-routing path width.
- SRCWD, 4, node ID width.

Ports:
- clk  in  1  core/NoC clock.
- rst  in  1  asynchronous active-low reset.
- route_wr_en  in  1  write the route-table entry selected by route_wr_id.
- route_wr_id  in  4  AXI ID of the accepted request.
- route_wr_path  in  PATHWD  return path to the initiator.
- route_wr_dst  in  SRCWD  initiator node ID.
- SOURCE  in  SRCWD  this target's node ID.
- BID  in  4  write response ID.
- BRESP  in  2  write response code.
- BVALID  in  1  write response valid.
- BREADY  out  1  write response ready.
- RID  in  4  read data ID.
- RDATA  in  AXIRDATAWD  read data.
- RRESP  in  2  read response code.
- RLAST  in  1  last read beat.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- flit  out  FLIT_WIDTH  flit to out_buffer.
- valid  out  1  flit valid (out_buffer write).
- stall  in  1  out_buffer full.
- wr_resp_sent  out  1  one-cycle pulse when a B packet flit is accepted.
- rd_resp_sent  out  1  one-cycle pulse when an R tail flit is accepted.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; valid=0; flit=0; BREADY=0; RREADY=0; pulses=0; round-robin pointer=B.
  - Route table cleared to 0.
- Output register:
  - flit/valid are registered.
  - A flit is consumed on valid&&!stall.
  - When stall=1, flit and valid are held stable.
  - Define load = !valid || !stall.
- Flit type field [FLIT_WIDTH-1:FLIT_WIDTH-2]: 10=header, 00=body, 01=tail, 11=single.
- Header / single flit layout:
  - [6:0] path from table.
  - [10:7] dst.
  - [14:11] SOURCE.
  - [18:15] ID.
  - [19] is_read.
  - [21:20] BRESP (write responses; 0 for reads).
  - Other bits 0.
- Body / tail flit layout:
  - [63:0] RDATA.
  - [65:64] RRESP.
  - [66] RLAST.
  - Other bits 0.
- Route table:
  - Written on route_wr_en at the clock edge.
  - A lookup in the same cycle as a write to the same ID returns the new value (write bypass).
- FSM states: IDLE, B_SEND, R_HEAD, R_BODY.
- IDLE:
  - If BVALID&&RVALID, grant the channel selected by the round-robin pointer, then flip the pointer.
  - If only one is valid, grant it.
  - Grant B → B_SEND; grant R → R_HEAD.
- B_SEND:
  - BREADY = load.
  - On BVALID&&BREADY: load a single flit, pulse wr_resp_sent in the cycle it is loaded, go to IDLE.
- R_HEAD:
  - When load=1: load the header using RID, then go to R_BODY.
  - RREADY=0 in this state.
- R_BODY:
  - RREADY = load.
  - Each beat loads a flit: body if RLAST=0, tail if RLAST=1.
  - On the RLAST beat: pulse rd_resp_sent, go to IDLE.
- Arbitration happens only in IDLE; packets are never interleaved. B waits while an R burst is in progress.
- A burst with a single beat produces header + tail (2 flits). An N-beat burst produces N+1 flits.
- Throughput: one flit per cycle when stall=0; zero bubbles between consecutive packets is not required (one IDLE cycle is allowed).
- Reset asserted mid-packet: immediate return to IDLE; any partial packet is dropped.

Test Plan:
- Route write (id=3, path=7'h55, dst=2), SOURCE=4, then BID=3, BRESP=2 → exactly one flit: type 11, [6:0]=55h, [10:7]=2, [14:11]=4, [18:15]=3, [21:20]=2; wr_resp_sent pulses once.
- 4-beat R burst, RID=3, RDATA=1..4, stall=0 → header followed by 3 body + 1 tail flits, back-to-back; rd_resp_sent pulses once, coincident with the tail.
- Same burst with stall=1 for 3 cycles mid-burst → flit held unchanged, RREADY=0 while stalled, no data loss or duplication.
- BVALID and RVALID both held continuously → grants alternate B, R, B, R; no flit of a B packet appears inside an R packet.
- route_wr_en for id=5 in the same cycle a B with BID=5 is granted → header carries the newly written path.
- rst=0 asserted during the 2nd beat of a 4-beat burst → valid=0, BREADY=RREADY=0 immediately; after release, a new B packet forms correctly.

Source files
------------

// File: rtl/axi_ni_target_response_if.sv
// rtl/axi_ni_target_response_if.sv - slave B/R, route-write and flit-output bundle for the target response packetizer
interface axi_ni_target_response_if #(
   parameter int FLIT_WIDTH = 80,
   parameter int AXIRDATAWD = 64,
   parameter int PATHWD     = 7,
   parameter int SRCWD      = 4
);
   logic                  route_wr_en;
   logic [3:0]            route_wr_id;
   logic [PATHWD-1:0]     route_wr_path;
   logic [SRCWD-1:0]      route_wr_dst;
   logic [SRCWD-1:0]      SOURCE;

   logic [3:0]            BID;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   logic [3:0]            RID;
   logic [AXIRDATAWD-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   logic [FLIT_WIDTH-1:0] flit;
   logic                  valid;
   logic                  stall;
   logic                  wr_resp_sent;
   logic                  rd_resp_sent;

   // Packetizer side
   modport slave (
      input  route_wr_en, route_wr_id, route_wr_path, route_wr_dst, SOURCE,
      input  BID, BRESP, BVALID,
      output BREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY,
      output flit, valid,
      input  stall,
      output wr_resp_sent, rd_resp_sent
   );

   // Slave core / out_buffer side
   modport master (
      output route_wr_en, route_wr_id, route_wr_path, route_wr_dst, SOURCE,
      output BID, BRESP, BVALID,
      input  BREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY,
      input  flit, valid,
      output stall,
      input  wr_resp_sent, rd_resp_sent
   );
endinterface

// File: rtl/axi_ni_target_response.sv
// rtl/axi_ni_target_response.sv - packetizes AXI B responses and R bursts into NoC response flits
module axi_ni_target_response #(
   parameter int FLIT_WIDTH        = 80,
   parameter int MAX_SUPPORTED_IDS = 16,
   parameter int AXIRDATAWD        = 64,
   parameter int PATHWD            = 7,
   parameter int SRCWD             = 4
) (
   input logic                      clk,
   input logic                      rst,
   axi_ni_target_response_if.slave  bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_B_SEND = 2'd1;
   localparam logic [1:0] S_R_HEAD = 2'd2;
   localparam logic [1:0] S_R_BODY = 2'd3;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_TAIL   = 2'b01;
   localparam logic [1:0] T_HEAD   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   localparam int IDXW     = (MAX_SUPPORTED_IDS > 1) ? $clog2(MAX_SUPPORTED_IDS) : 1;
   // Header field positions, packed upward from the path field
   localparam int DST_LSB  = PATHWD;
   localparam int SRC_LSB  = DST_LSB + SRCWD;
   localparam int ID_LSB   = SRC_LSB + SRCWD;
   localparam int RD_BIT   = ID_LSB + 4;
   localparam int RESP_LSB = RD_BIT + 1;

   logic [1:0]            state, state_nxt;
   logic                  rr_r, rr_nxt;          // 0: B wins next contention, 1: R wins
   logic [PATHWD-1:0]     path_tbl [MAX_SUPPORTED_IDS];
   logic [SRCWD-1:0]      dst_tbl  [MAX_SUPPORTED_IDS];

   logic [FLIT_WIDTH-1:0] flit_r;
   logic                  valid_r;
   logic                  wr_pulse_r, rd_pulse_r;

   logic                  load, b_hs, r_hs;
   logic                  new_valid;
   logic [FLIT_WIDTH-1:0] new_flit, hdr_flit, body_flit;
   logic [3:0]            lk_id;
   logic                  lk_hit;
   logic [PATHWD-1:0]     lk_path;
   logic [SRCWD-1:0]      lk_dst;

   // The output register can take a new flit whenever it is empty or draining
   assign load   = !valid_r || !bus.stall;
   assign bus.BREADY = (state == S_B_SEND) && load;
   assign bus.RREADY = (state == S_R_BODY) && load;
   assign b_hs   = bus.BVALID && bus.BREADY;
   assign r_hs   = bus.RVALID && bus.RREADY;

   assign bus.flit         = flit_r;
   assign bus.valid        = valid_r;
   assign bus.wr_resp_sent = wr_pulse_r;
   assign bus.rd_resp_sent = rd_pulse_r;

   // Route lookup for the packet being started; a same-cycle write to the same ID wins
   assign lk_id   = (state == S_B_SEND) ? bus.BID : bus.RID;
   assign lk_hit  = bus.route_wr_en && (bus.route_wr_id == lk_id);
   assign lk_path = lk_hit ? bus.route_wr_path : path_tbl[lk_id[IDXW-1:0]];
   assign lk_dst  = lk_hit ? bus.route_wr_dst  : dst_tbl[lk_id[IDXW-1:0]];

   // Header/single and body/tail payloads, type bits filled in by the FSM
   always_comb begin
      hdr_flit = '0;
      hdr_flit[PATHWD-1:0]        = lk_path;
      hdr_flit[DST_LSB +: SRCWD]  = lk_dst;
      hdr_flit[SRC_LSB +: SRCWD]  = bus.SOURCE;
      hdr_flit[ID_LSB +: 4]       = lk_id;
      hdr_flit[RD_BIT]            = (state == S_R_HEAD);
      hdr_flit[RESP_LSB +: 2]     = (state == S_B_SEND) ? bus.BRESP : 2'b00;

      body_flit = '0;
      body_flit[AXIRDATAWD-1:0]   = bus.RDATA;
      body_flit[AXIRDATAWD +: 2]  = bus.RRESP;
      body_flit[AXIRDATAWD + 2]   = bus.RLAST;
   end

   // Arbitration and packet sequencing; one packet at a time
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_r;
      new_valid = 1'b0;
      new_flit  = '0;
      case (state)
         S_IDLE: begin
            if (bus.BVALID && bus.RVALID) begin
               state_nxt = rr_r ? S_R_HEAD : S_B_SEND;
               rr_nxt    = !rr_r;
            end else if (bus.BVALID) begin
               state_nxt = S_B_SEND;
            end else if (bus.RVALID) begin
               state_nxt = S_R_HEAD;
            end
         end
         S_B_SEND: begin
            if (b_hs) begin
               new_valid = 1'b1;
               new_flit  = hdr_flit;
               new_flit[FLIT_WIDTH-1 -: 2] = T_SINGLE;
               state_nxt = S_IDLE;
            end
         end
         S_R_HEAD: begin
            if (load) begin
               new_valid = 1'b1;
               new_flit  = hdr_flit;
               new_flit[FLIT_WIDTH-1 -: 2] = T_HEAD;
               state_nxt = S_R_BODY;
            end
         end
         default: begin
            if (r_hs) begin
               new_valid = 1'b1;
               new_flit  = body_flit;
               new_flit[FLIT_WIDTH-1 -: 2] = bus.RLAST ? T_TAIL : T_BODY;
               if (bus.RLAST) state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // FSM, output register and completion pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rr_r       <= 1'b0;
         valid_r    <= 1'b0;
         flit_r     <= '0;
         wr_pulse_r <= 1'b0;
         rd_pulse_r <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_r       <= rr_nxt;
         if (load) begin
            valid_r <= new_valid;
            if (new_valid) flit_r <= new_flit;
         end
         wr_pulse_r <= b_hs;
         rd_pulse_r <= r_hs && bus.RLAST;
      end
   end

   // Return-route table written by the request path
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            path_tbl[i] <= '0;
            dst_tbl[i]  <= '0;
         end
      end else if (bus.route_wr_en) begin
         path_tbl[bus.route_wr_id[IDXW-1:0]] <= bus.route_wr_path;
         dst_tbl[bus.route_wr_id[IDXW-1:0]]  <= bus.route_wr_dst;
      end
   end
endmodule

// File: tb/tb_axi_ni_target_response.sv
// tb/tb_axi_ni_target_response.sv - scoreboard bench for the target response packetizer
module tb_axi_ni_target_response;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = !clk;

   axi_ni_target_response_if #(.FLIT_WIDTH(80), .AXIRDATAWD(64), .PATHWD(7), .SRCWD(4)) bus_if ();

   axi_ni_target_response #(
      .FLIT_WIDTH(80), .MAX_SUPPORTED_IDS(16), .AXIRDATAWD(64), .PATHWD(7), .SRCWD(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [79:0] flit;
      logic        wr;
      logic        rd;
      int          cyc;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int stray = 0;
   int cyc = 0;
   logic cur_wr = 1'b0;
   logic cur_rd = 1'b0;
   logic [6:0] mpath [16];
   logic [3:0] mdst [16];
   logic [3:0] src = 4'd4;

   function automatic logic [79:0] f_hdr(logic [1:0] t, logic [3:0] id, logic rd, logic [1:0] br);
      logic [79:0] f;
      f = '0;
      f[79:78] = t;
      f[6:0]   = mpath[id];
      f[10:7]  = mdst[id];
      f[14:11] = src;
      f[18:15] = id;
      f[19]    = rd;
      f[21:20] = br;
      return f;
   endfunction

   function automatic logic [79:0] f_body(logic [63:0] d, logic [1:0] resp, logic last);
      logic [79:0] f;
      f = '0;
      f[79:78] = last ? 2'b01 : 2'b00;
      f[63:0]  = d;
      f[65:64] = resp;
      f[66]    = last;
      return f;
   endfunction

   task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
      exp_q.push_back('{f_hdr(2'b11, id, 1'b0, resp), 1'b1, 1'b0, 0});
   endtask

   task automatic push_r(input logic [3:0] id, input int n, input logic [63:0] base);
      exp_q.push_back('{f_hdr(2'b10, id, 1'b1, 2'b00), 1'b0, 1'b0, 0});
      for (int k = 0; k < n; k++)
         exp_q.push_back('{f_body(base + 64'(k), 2'(k), k == n - 1), 1'b0, k == n - 1, 0});
   endtask

   // Accepted flits are captured with any completion pulse seen while they were presented
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst) begin
         cur_wr = 1'b0;
         cur_rd = 1'b0;
      end else if (bus_if.valid) begin
         cur_wr = cur_wr | bus_if.wr_resp_sent;
         cur_rd = cur_rd | bus_if.rd_resp_sent;
         if (!bus_if.stall) begin
            obs_q.push_back('{bus_if.flit, cur_wr, cur_rd, cyc});
            cur_wr = 1'b0;
            cur_rd = 1'b0;
         end
      end else if (bus_if.wr_resp_sent || bus_if.rd_resp_sent) begin
         stray++;
      end
   end

   task automatic write_route(input logic [3:0] id, input logic [6:0] p, input logic [3:0] d);
      bus_if.route_wr_en = 1'b1;
      bus_if.route_wr_id = id;
      bus_if.route_wr_path = p;
      bus_if.route_wr_dst = d;
      mpath[id] = p;
      mdst[id] = d;
      @(negedge clk);
      bus_if.route_wr_en = 1'b0;
   endtask

   task automatic drive_b(input logic [3:0] id, input logic [1:0] resp);
      logic hs;
      int n;
      n = 0;
      bus_if.BID = id;
      bus_if.BRESP = resp;
      bus_if.BVALID = 1'b1;
      do begin
         #1 hs = bus_if.BREADY;
         @(negedge clk);
         n++;
      end while (!hs && n < 200);
      bus_if.BVALID = 1'b0;
      total_cnt++;
      if (!hs) $display("FAIL b_handshake_timeout act=no_BREADY exp=handshake id=%0d", id);
      else pass_cnt++;
   endtask

   task automatic drive_r(input logic [3:0] id, input int beats, input logic [63:0] base);
      logic hs;
      int n;
      for (int k = 0; k < beats; k++) begin
         n = 0;
         bus_if.RID = id;
         bus_if.RDATA = base + 64'(k);
         bus_if.RRESP = 2'(k);
         bus_if.RLAST = (k == beats - 1);
         bus_if.RVALID = 1'b1;
         do begin
            #1 hs = bus_if.RREADY;
            @(negedge clk);
            n++;
         end while (!hs && n < 200);
         total_cnt++;
         if (!hs) $display("FAIL r_handshake_timeout act=no_RREADY exp=handshake beat=%0d", k);
         else pass_cnt++;
      end
      bus_if.RVALID = 1'b0;
      bus_if.RLAST = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      int c;
      c = 0;
      while (obs_q.size() < n && c < 500) begin
         @(negedge clk);
         c++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      bus_if.BVALID = 1'b1;
      bus_if.RVALID = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total_cnt += 6;
      if (bus_if.valid !== 1'b0) $display("FAIL reset_valid act=%b exp=0", bus_if.valid); else pass_cnt++;
      if (bus_if.flit !== 80'h0) $display("FAIL reset_flit act=%h exp=0", bus_if.flit); else pass_cnt++;
      if (bus_if.BREADY !== 1'b0) $display("FAIL reset_bready act=%b exp=0", bus_if.BREADY); else pass_cnt++;
      if (bus_if.RREADY !== 1'b0) $display("FAIL reset_rready act=%b exp=0", bus_if.RREADY); else pass_cnt++;
      if (bus_if.wr_resp_sent !== 1'b0) $display("FAIL reset_wr_pulse act=%b exp=0", bus_if.wr_resp_sent); else pass_cnt++;
      if (bus_if.rd_resp_sent !== 1'b0) $display("FAIL reset_rd_pulse act=%b exp=0", bus_if.rd_resp_sent); else pass_cnt++;
      bus_if.BVALID = 1'b0;
      bus_if.RVALID = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_b_single();
      rec_t e, o;
      write_route(4'd3, 7'h55, 4'd2);
      push_b(4'd3, 2'd2);
      drive_b(4'd3, 2'd2);
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL b_single_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt += 2;
         if (o.flit !== e.flit) $display("FAIL b_single_flit act=%h exp=%h", o.flit, e.flit); else pass_cnt++;
         if ({o.wr, o.rd} !== {e.wr, e.rd}) $display("FAIL b_single_pulses act=%b%b exp=%b%b", o.wr, o.rd, e.wr, e.rd); else pass_cnt++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_r_burst();
      rec_t e, o;
      int first, k;
      push_r(4'd3, 4, 64'd1);
      drive_r(4'd3, 4, 64'd1);
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL r_burst_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      first = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt += 3;
         if (o.flit !== e.flit) $display("FAIL r_burst_flit%0d act=%h exp=%h", k, o.flit, e.flit); else pass_cnt++;
         if ({o.wr, o.rd} !== {e.wr, e.rd}) $display("FAIL r_burst_pulses%0d act=%b%b exp=%b%b", k, o.wr, o.rd, e.wr, e.rd); else pass_cnt++;
         if (o.cyc !== first + k) $display("FAIL r_burst_b2b%0d act=%0d exp=%0d", k, o.cyc, first + k); else pass_cnt++;
         k++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_stall();
      rec_t e, o;
      logic [79:0] held;
      push_r(4'd3, 4, 64'd1);
      fork
         drive_r(4'd3, 4, 64'd1);
         begin
            repeat (3) @(negedge clk);
            bus_if.stall = 1'b1;
            #1 held = bus_if.flit;
            for (int s = 0; s < 3; s++) begin
               #1;
               total_cnt += 3;
               if (bus_if.RREADY !== 1'b0) $display("FAIL stall_rready%0d act=%b exp=0", s, bus_if.RREADY); else pass_cnt++;
               if (bus_if.flit !== held) $display("FAIL stall_hold%0d act=%h exp=%h", s, bus_if.flit, held); else pass_cnt++;
               if (bus_if.valid !== 1'b1) $display("FAIL stall_valid%0d act=%b exp=1", s, bus_if.valid); else pass_cnt++;
               @(negedge clk);
            end
            bus_if.stall = 1'b0;
         end
      join
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL stall_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt += 2;
         if (o.flit !== e.flit) $display("FAIL stall_flit act=%h exp=%h", o.flit, e.flit); else pass_cnt++;
         if ({o.wr, o.rd} !== {e.wr, e.rd}) $display("FAIL stall_pulses act=%b%b exp=%b%b", o.wr, o.rd, e.wr, e.rd); else pass_cnt++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_arbitration();
      rec_t e, o;
      int k;
      push_b(4'd3, 2'd1);
      push_r(4'd3, 2, 64'h10);
      push_b(4'd3, 2'd3);
      push_r(4'd3, 3, 64'h20);
      fork
         begin
            drive_b(4'd3, 2'd1);
            drive_b(4'd3, 2'd3);
         end
         begin
            drive_r(4'd3, 2, 64'h10);
            drive_r(4'd3, 3, 64'h20);
         end
      join
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL arb_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt += 2;
         if (o.flit !== e.flit) $display("FAIL arb_flit%0d act=%h exp=%h", k, o.flit, e.flit); else pass_cnt++;
         if ({o.wr, o.rd} !== {e.wr, e.rd}) $display("FAIL arb_pulses%0d act=%b%b exp=%b%b", k, o.wr, o.rd, e.wr, e.rd); else pass_cnt++;
         k++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_route_bypass();
      rec_t e, o;
      write_route(4'd5, 7'h11, 4'd1);
      // route written in the grant cycle
      bus_if.route_wr_en = 1'b1;
      bus_if.route_wr_id = 4'd5;
      bus_if.route_wr_path = 7'h2A;
      bus_if.route_wr_dst = 4'd9;
      mpath[5] = 7'h2A;
      mdst[5] = 4'd9;
      push_b(4'd5, 2'd1);
      fork
         drive_b(4'd5, 2'd1);
         begin
            @(negedge clk);
            bus_if.route_wr_en = 1'b0;
         end
      join
      // route written in the cycle the single flit is formed
      mpath[5] = 7'h7E;
      mdst[5] = 4'hC;
      push_b(4'd5, 2'd3);
      fork
         drive_b(4'd5, 2'd3);
         begin
            @(negedge clk);
            bus_if.route_wr_en = 1'b1;
            bus_if.route_wr_path = 7'h7E;
            bus_if.route_wr_dst = 4'hC;
            @(negedge clk);
            bus_if.route_wr_en = 1'b0;
         end
      join
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL bypass_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt++;
         if (o.flit !== e.flit) $display("FAIL bypass_flit act=%h exp=%h", o.flit, e.flit); else pass_cnt++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid_burst();
      rec_t e, o;
      logic hs;
      int n;
      bus_if.RID = 4'd3;
      bus_if.RDATA = 64'd1;
      bus_if.RRESP = 2'd0;
      bus_if.RLAST = 1'b0;
      bus_if.RVALID = 1'b1;
      n = 0;
      do begin
         #1 hs = bus_if.RREADY;
         @(negedge clk);
         n++;
      end while (!hs && n < 200);
      bus_if.RDATA = 64'd2;
      #1 rst = 1'b0;
      #1;
      total_cnt += 4;
      if (bus_if.valid !== 1'b0) $display("FAIL midrst_valid act=%b exp=0", bus_if.valid); else pass_cnt++;
      if (bus_if.BREADY !== 1'b0) $display("FAIL midrst_bready act=%b exp=0", bus_if.BREADY); else pass_cnt++;
      if (bus_if.RREADY !== 1'b0) $display("FAIL midrst_rready act=%b exp=0", bus_if.RREADY); else pass_cnt++;
      if (bus_if.flit !== 80'h0) $display("FAIL midrst_flit act=%h exp=0", bus_if.flit); else pass_cnt++;
      bus_if.RVALID = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mpath[i] = '0;
         mdst[i] = '0;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      obs_q.delete();
      exp_q.delete();
      write_route(4'd6, 7'h33, 4'd7);
      push_b(4'd6, 2'd1);
      push_b(4'd3, 2'd0);
      drive_b(4'd6, 2'd1);
      drive_b(4'd3, 2'd0);
      wait_obs(exp_q.size());
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL post_rst_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total_cnt += 2;
         if (o.flit !== e.flit) $display("FAIL post_rst_flit act=%h exp=%h", o.flit, e.flit); else pass_cnt++;
         if ({o.wr, o.rd} !== {e.wr, e.rd}) $display("FAIL post_rst_pulses act=%b%b exp=%b%b", o.wr, o.rd, e.wr, e.rd); else pass_cnt++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_stray_pulses();
      total_cnt++;
      if (stray !== 0) $display("FAIL stray_pulses act=%0d exp=0", stray); else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mpath[i] = '0;
         mdst[i] = '0;
      end
      bus_if.route_wr_en = 1'b0;
      bus_if.route_wr_id = '0;
      bus_if.route_wr_path = '0;
      bus_if.route_wr_dst = '0;
      bus_if.SOURCE = 4'd4;
      bus_if.BID = '0;
      bus_if.BRESP = '0;
      bus_if.BVALID = 1'b0;
      bus_if.RID = '0;
      bus_if.RDATA = '0;
      bus_if.RRESP = '0;
      bus_if.RLAST = 1'b0;
      bus_if.RVALID = 1'b0;
      bus_if.stall = 1'b0;
      test_reset();
      test_b_single();
      test_r_burst();
      test_stall();
      test_arbitration();
      test_route_bypass();
      test_reset_mid_burst();
      test_stray_pulses();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
